// File: rtl/instruction_fetch_pkg.sv
// Shared processor package: fetch FSM encoding, fixed instruction encodings,
// IF/ID payload layout and an address alignment helper.
package instruction_fetch_pkg;

    localparam int unsigned XLEN = 32;

    // Fetching this word stops the front end; it is never handed to decode.
    localparam logic [XLEN-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    // Bubble contents written into IF/ID on flush.
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // IF/ID payload: fetched word and the address following it.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
    } if_id_t;

    // Folds a byte address into the memory window and forces word alignment.
    function automatic logic [XLEN-1:0] align_addr(input logic [XLEN-1:0] addr,
                                                   input logic [XLEN-1:0] mem_mask);
        return addr & mem_mask & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register.
// Ports: clk/rst, flush (bubble, highest priority), load (capture d),
// otherwise hold; instr/pc4/valid are the registered payload.
module if_id_reg
    import instruction_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  if_id_t          d,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc4,
    output logic            valid
);

    // Flush wins over load; neither asserted means hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr <= NOP_INSTR;
            pc4   <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= NOP_INSTR;
            pc4   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            instr <= d.instr;
            pc4   <= d.pc4;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, IDLE/RUN/HALT control and IF/ID register.
// Ports: clk, rst (async, active high), start/stall/redirect_en/redirect_pc
// control, PC to instruction memory, instruction back from memory (same cycle),
// if_id_instr/if_id_pc4/if_id_valid to decode, halted and fetch_count status.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 16384,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic [31:0] PC,
    input  logic [31:0] instruction,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    // MEM_BYTES is a power of two, so wrap is a mask.
    localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc_nxt;
    logic [31:0]  pc_plus4;
    logic         ifid_load;
    logic         ifid_flush;
    logic         count_en;
    if_id_t       ifid_d;

    assign pc_plus4 = align_addr(PC + 32'd4, ADDR_MASK);
    assign ifid_d   = '{instr: instruction, pc4: pc_plus4};

    // Next state: start > redirect > stall > halt detect > advance.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = PC;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        count_en   = 1'b0;
        case (state)
            IDLE: begin
                pc_nxt     = RESET_PC;
                ifid_flush = 1'b1;
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (start) begin
                    pc_nxt     = RESET_PC;
                    ifid_flush = 1'b1;
                end else if (redirect_en) begin
                    pc_nxt     = align_addr(redirect_pc, ADDR_MASK);
                    ifid_flush = 1'b1;
                end else if (stall) begin
                    pc_nxt = PC;
                end else if (instruction == HALT_WORD) begin
                    // Halt word becomes a bubble; PC parks on it.
                    state_nxt  = HALT;
                    ifid_flush = 1'b1;
                end else begin
                    pc_nxt    = pc_plus4;
                    ifid_load = 1'b1;
                    count_en  = 1'b1;
                end
            end
            HALT: begin
                ifid_flush = 1'b1;
                if (start) begin
                    state_nxt = RUN;
                    pc_nxt    = RESET_PC;
                end
            end
            default: begin
                state_nxt  = IDLE;
                pc_nxt     = RESET_PC;
                ifid_flush = 1'b1;
            end
        endcase
    end

    // State, PC and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            PC          <= RESET_PC;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            state  <= state_nxt;
            PC     <= pc_nxt;
            halted <= (state_nxt == HALT);
            if (count_en) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

    if_id_reg u_if_id (
        .clk   (clk),
        .rst   (rst),
        .load  (ifid_load),
        .flush (ifid_flush),
        .d     (ifid_d),
        .instr (if_id_instr),
        .pc4   (if_id_pc4),
        .valid (if_id_valid)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch with a word-addressed memory model
// and a scoreboard of expected IF/ID deliveries.
module tb_instruction_fetch;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stall;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:4095];
    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] prev_count = '0;

    always #5 clk = ~clk;

    assign instruction = mem[pc[13:2]];

    instruction_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stall       (stall),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .PC          (pc),
        .instruction (instruction),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int word_idx, input logic [31:0] pc4);
        exp_t e;
        e.instr = mem[word_idx];
        e.pc4   = pc4;
        exp_q.push_back(e);
    endtask

    // Each single-step rise of fetch_count is one delivery to compare.
    always @(negedge clk) begin
        if (fetch_count == prev_count + 32'd1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", fetch_count, prev_count);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_instr", if_id_instr, e.instr);
                check("sb_pc4", if_id_pc4, e.pc4);
                check("sb_valid", 32'(if_id_valid), 32'd1);
            end
        end
        prev_count = fetch_count;
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
        rst = 1'b1; start = 1'b0; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
        cyc(2);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", if_id_instr, 32'h0);
        check("rst_pc4", if_id_pc4, 32'h0);
        check("rst_valid", 32'(if_id_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_count", fetch_count, 32'h0);
        rst = 1'b0;
        cyc(1);
        check("idle_valid", 32'(if_id_valid), 32'd0);

        // Four sequential fetches from reset.
        for (int i = 0; i < 4; i++) push(i, 32'(4 * (i + 1)));
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("start_pc", pc, 32'h0);
        check("start_valid", 32'(if_id_valid), 32'd0);
        cyc(4);
        stall = 1'b1;
        check("seq_count", fetch_count, 32'd4);
        check("seq_pc", pc, 32'h10);

        // Stall held three cycles at 0x10.
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check("stall_pc", pc, 32'h10);
            check("stall_instr", if_id_instr, mem[3]);
            check("stall_pc4", if_id_pc4, 32'h10);
            check("stall_valid", 32'(if_id_valid), 32'd1);
            check("stall_count", fetch_count, 32'd4);
        end
        push(4, 32'h14);
        stall = 1'b0;
        cyc(1);
        stall = 1'b1;
        check("unstall_pc", pc, 32'h14);
        check("unstall_count", fetch_count, 32'd5);

        // Redirect wins over stall and is masked/aligned.
        redirect_en = 1'b1; redirect_pc = 32'h0000_00A7;
        cyc(1);
        redirect_en = 1'b0;
        check("redir_pc", pc, 32'hA4);
        check("redir_valid", 32'(if_id_valid), 32'd0);
        check("redir_instr", if_id_instr, 32'h0);
        check("redir_count", fetch_count, 32'd5);

        // Wrap from the last word of memory.
        redirect_en = 1'b1; redirect_pc = 32'h0000_3FFC;
        cyc(1);
        redirect_en = 1'b0;
        check("wrap_pre_pc", pc, 32'h3FFC);
        push(4095, 32'h0);
        stall = 1'b0;
        cyc(1);
        stall = 1'b1;
        check("wrap_pc", pc, 32'h0);
        check("wrap_pc4", if_id_pc4, 32'h0);
        check("wrap_count", fetch_count, 32'd6);

        // Asynchronous reset between edges.
        push(0, 32'h4);
        stall = 1'b0;
        cyc(1);
        #6;
        rst = 1'b1;
        #1;
        check("arst_pc", pc, 32'h0);
        check("arst_valid", 32'(if_id_valid), 32'd0);
        check("arst_instr", if_id_instr, 32'h0);
        check("arst_pc4", if_id_pc4, 32'h0);
        check("arst_count", fetch_count, 32'h0);
        check("arst_halted", 32'(halted), 32'd0);
        cyc(2);
        rst = 1'b0;
        cyc(3);
        check("post_rst_valid", 32'(if_id_valid), 32'd0);
        check("post_rst_count", fetch_count, 32'h0);
        check("post_rst_pc", pc, 32'h0);

        // Halt word at 0x20.
        mem[8] = HALT_W;
        for (int i = 0; i < 8; i++) push(i, 32'(4 * (i + 1)));
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(8);
        check("pre_halt_pc", pc, 32'h20);
        check("pre_halt_count", fetch_count, 32'd8);
        check("pre_halt_halted", 32'(halted), 32'd0);
        cyc(1);
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_pc", pc, 32'h20);
        check("halt_valid", 32'(if_id_valid), 32'd0);
        check("halt_count", fetch_count, 32'd8);
        redirect_en = 1'b1; redirect_pc = 32'h80; stall = 1'b1;
        cyc(2);
        check("halt_ign_pc", pc, 32'h20);
        check("halt_ign_halted", 32'(halted), 32'd1);
        check("halt_ign_count", fetch_count, 32'd8);
        redirect_en = 1'b0; stall = 1'b0; start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("restart_pc", pc, 32'h0);
        check("restart_halted", 32'(halted), 32'd0);
        check("restart_valid", 32'(if_id_valid), 32'd0);
        push(0, 32'h4);
        cyc(1);
        check("restart_count", fetch_count, 32'd9);
        check("restart_adv_pc", pc, 32'h4);

        // Start outranks redirect while running.
        start = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h40;
        cyc(1);
        start = 1'b0; redirect_en = 1'b0; stall = 1'b1;
        check("start_vs_redir_pc", pc, 32'h0);
        check("start_vs_redir_valid", 32'(if_id_valid), 32'd0);
        check("start_vs_redir_count", fetch_count, 32'd9);
        cyc(2);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: byte address loaded into PC on reset and on restart.
REQ-002 Parameter MEM_BYTES, default 16384: instruction memory size in bytes; power of two.
REQ-003 Parameter HALT_WORD, default 32'hFFFF_FFFF: fetched word that halts fetch.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle pulse; begins or restarts fetching from RESET_PC.
REQ-007 stall  input  1  holds PC and IF/ID register.
REQ-008 redirect_en  input  1  branch/jump taken; load redirect_pc.
REQ-009 redirect_pc  input  32  redirect byte address.
REQ-010 PC  output  32  fetch address to instruction memory, combinational from PC register.
REQ-011 instruction  input  32  word returned by instruction memory, big-endian, same cycle as PC.
REQ-012 if_id_instr  output  32  registered fetched word.
REQ-013 if_id_pc4  output  32  registered address of the fetched word plus 4, wrapped.
REQ-014 if_id_valid  output  1  if_id_instr holds a real instruction.
REQ-015 halted  output  1  fetch is in HALT.
REQ-016 fetch_count  output  32  count of words delivered with if_id_valid=1.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and HALT; reset enters IDLE.
REQ-018 IDLE: PC holds RESET_PC, if_id_valid=0; start moves to RUN next cycle.
REQ-019 RUN, no stall, no redirect: IF/ID SHALL capture {instruction, PC+4, valid=1}; PC becomes PC+4; latency from PC to if_id_instr is one cycle.
REQ-020 Wrap: all PC arithmetic SHALL be modulo MEM_BYTES; PC = MEM_BYTES-4 advances to 0, if_id_pc4 = 0.
REQ-021 Alignment: PC bits [1:0] SHALL always be 0; redirect_pc is masked to {redirect_pc & (MEM_BYTES-1)} with bits [1:0] cleared.
REQ-022 redirect_en in RUN: PC SHALL load masked redirect_pc; IF/ID SHALL be flushed (valid=0, instr=0) the same edge.
REQ-023 Priority: rst > redirect_en > stall > normal advance; redirect with stall performs the redirect.
REQ-024 stall without redirect: PC, IF/ID and fetch_count SHALL hold unchanged.
REQ-025 In RUN, when instruction == HALT_WORD and neither stall nor redirect is asserted: move to HALT, PC holds, IF/ID loads bubble (valid=0); the halt word is never delivered.
REQ-026 HALT: PC holds, if_id_valid=0, halted=1, stall/redirect ignored; start returns to RUN with PC=RESET_PC.
REQ-027 start in RUN SHALL restart: PC=RESET_PC, IF/ID flushed; start outranks redirect_en.
REQ-028 fetch_count SHALL increment on each edge that writes if_id_valid=1, wrap at 2^32, and hold through HALT; it clears only on rst.
REQ-029 PC, if_id_* and halted SHALL change only on rising clk edges or rst.

Reset
REQ-030 On rst: state=IDLE, PC=RESET_PC, if_id_instr=0, if_id_pc4=0, if_id_valid=0, halted=0, fetch_count=0.
REQ-031 rst asserted mid-RUN SHALL abort immediately; no further valid words until a later start pulse.

Structure
REQ-032 FSM state encoding, HALT_WORD default and NOP encoding (32'h0) SHALL live in the shared processor package.
REQ-033 The IF/ID register SHALL be one sub-module, if_id_reg, with load, flush and hold controls; the PC/FSM logic stays in instruction_fetch.

Verification
REQ-034 Reset then start, memory words W0..W3 at 0,4,8,12 -> if_id_instr W0..W3 on four consecutive cycles, if_id_pc4 4,8,12,16, fetch_count=4.
REQ-035 RUN at PC=0x3FFC, MEM_BYTES=16384 -> next PC=0, if_id_pc4=0x0000_0000.
REQ-036 redirect_en with stall, redirect_pc=0x0000_00A7 -> PC=0x0000_00A4 next cycle, if_id_valid=0, fetch_count unchanged.
REQ-037 HALT_WORD placed at address 0x20 -> halted=1 after PC reaches 0x20, PC stays 0x20, fetch_count=8; start -> PC=0, halted=0.
REQ-038 stall held 3 cycles at PC=0x10 -> PC and if_id_* constant 3 cycles, then advance to 0x14.
REQ-039 rst pulsed asynchronously mid-RUN between edges -> all outputs at reset values immediately; no valid word until start.
